// File: rtl/jedro_1_lsu.sv
// Load/store unit: one outstanding data-bus access at a time, with byte-lane steering,
// load extension, misalignment/bus-error/timeout exceptions and register writeback.
module jedro_1_lsu #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      ctrl_valid_i,
    output logic                      ctrl_ready_o,
    input  logic                      ctrl_we_i,
    input  logic [1:0]                ctrl_size_i,
    input  logic                      ctrl_unsigned_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_addr_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] ctrl_regdest_i,

    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      done_o,
    output logic                      exc_misaligned_o,
    output logic                      exc_bus_err_o,
    output logic                      exc_timeout_o,
    output logic [DATA_WIDTH-1:0]     exc_addr_o,

    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    input  logic                      data_rvalid_i,
    output logic                      data_we_o,
    output logic [DATA_WIDTH/8-1:0]   data_be_o,
    output logic [DATA_WIDTH-1:0]     data_addr_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    input  logic                      data_err_i
);

    localparam int unsigned NB   = DATA_WIDTH / 8;
    localparam int unsigned OFFW = (DATA_WIDTH == 64) ? 3 : 2;

    localparam logic [DATA_WIDTH-1:0] MaskB = DATA_WIDTH'(64'hFF);
    localparam logic [DATA_WIDTH-1:0] MaskH = DATA_WIDTH'(64'hFFFF);
    localparam logic [DATA_WIDTH-1:0] MaskW = DATA_WIDTH'(64'hFFFF_FFFF);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                    r_state;
    logic [31:0]               r_cnt;
    logic [1:0]                r_size;
    logic                      r_unsigned;
    logic [OFFW-1:0]           r_off;
    logic [DATA_WIDTH-1:0]     r_addr;
    logic [REG_ADDR_WIDTH-1:0] r_regdest;

    logic [OFFW-1:0]           w_off;
    logic                      w_misaligned;
    logic [NB-1:0]             w_be;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [DATA_WIDTH-1:0]     w_aligned;
    logic [DATA_WIDTH-1:0]     w_shift;
    logic [DATA_WIDTH-1:0]     w_mask;
    logic                      w_sign;
    logic [DATA_WIDTH-1:0]     w_ext;
    logic                      w_timeout;

    assign ctrl_ready_o = (r_state == StIdle);
    assign w_off        = ctrl_addr_i[OFFW-1:0];
    assign w_aligned    = {ctrl_addr_i[DATA_WIDTH-1:OFFW], OFFW'(0)};
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && ((r_cnt + 32'd1) == TIMEOUT_CYCLES);

    // Request-side decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        w_misaligned = 1'b0;
        w_be         = '1;
        w_wdata      = ctrl_wdata_i;
        unique case (ctrl_size_i)
            2'b00: begin
                w_be    = NB'(1) << w_off;
                w_wdata = {NB{ctrl_wdata_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = ctrl_addr_i[0];
                w_be         = NB'(2'b11) << w_off;
                w_wdata      = {(NB/2){ctrl_wdata_i[15:0]}};
            end
            2'b10: begin
                w_misaligned = |ctrl_addr_i[1:0];
                w_be         = NB'(4'hF) << w_off;
                w_wdata      = {(NB/4){ctrl_wdata_i[31:0]}};
            end
            default: begin
                w_misaligned = (DATA_WIDTH == 32) || (|ctrl_addr_i[2:0]);
                w_be         = '1;
                w_wdata      = ctrl_wdata_i;
            end
        endcase
    end

    // Load extension: shift the addressed lane down, then sign- or zero-fill above the size.
    always_comb begin
        w_shift = data_rdata_i >> {r_off, 3'b000};
        w_mask  = '1;
        w_sign  = 1'b0;
        unique case (r_size)
            2'b00: begin
                w_mask = MaskB;
                w_sign = w_shift[7];
            end
            2'b01: begin
                w_mask = MaskH;
                w_sign = w_shift[15];
            end
            2'b10: begin
                w_mask = MaskW;
                w_sign = w_shift[31];
            end
            default: begin
                w_mask = '1;
                w_sign = w_shift[DATA_WIDTH-1];
            end
        endcase
        w_ext = (w_shift & w_mask) | (~w_mask & {DATA_WIDTH{w_sign & ~r_unsigned}});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= StIdle;
            r_cnt            <= '0;
            r_size           <= '0;
            r_unsigned       <= 1'b0;
            r_off            <= '0;
            r_addr           <= '0;
            r_regdest        <= '0;
            rf_we_o          <= 1'b0;
            rf_waddr_o       <= '0;
            rf_wdata_o       <= '0;
            done_o           <= 1'b0;
            exc_misaligned_o <= 1'b0;
            exc_bus_err_o    <= 1'b0;
            exc_timeout_o    <= 1'b0;
            exc_addr_o       <= '0;
            data_req_o       <= 1'b0;
            data_we_o        <= 1'b0;
            data_be_o        <= '0;
            data_addr_o      <= '0;
            data_wdata_o     <= '0;
        end else begin
            rf_we_o          <= 1'b0;
            done_o           <= 1'b0;
            exc_misaligned_o <= 1'b0;
            exc_bus_err_o    <= 1'b0;
            exc_timeout_o    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (ctrl_valid_i) begin
                        if (w_misaligned) begin
                            exc_misaligned_o <= 1'b1;
                            exc_addr_o       <= ctrl_addr_i;
                        end else begin
                            r_state      <= StReq;
                            r_size       <= ctrl_size_i;
                            r_unsigned   <= ctrl_unsigned_i;
                            r_off        <= w_off;
                            r_addr       <= ctrl_addr_i;
                            r_regdest    <= ctrl_regdest_i;
                            data_req_o   <= 1'b1;
                            data_we_o    <= ctrl_we_i;
                            data_be_o    <= w_be;
                            data_addr_o  <= w_aligned;
                            data_wdata_o <= w_wdata;
                        end
                    end
                end
                StReq: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_timeout) begin
                        exc_timeout_o <= 1'b1;
                        exc_addr_o    <= r_addr;
                        data_req_o    <= 1'b0;
                        r_state       <= StIdle;
                    end else if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        r_state    <= StResp;
                    end
                end
                StResp: begin
                    r_cnt <= r_cnt + 32'd1;
                    // A response landing on the timeout cycle still completes the access.
                    if (data_rvalid_i) begin
                        r_state <= StIdle;
                        if (data_err_i) begin
                            exc_bus_err_o <= 1'b1;
                            exc_addr_o    <= r_addr;
                        end else begin
                            done_o <= 1'b1;
                            if (!data_we_o) begin
                                rf_we_o    <= 1'b1;
                                rf_waddr_o <= r_regdest;
                                rf_wdata_o <= w_ext;
                            end
                        end
                    end else if (w_timeout) begin
                        exc_timeout_o <= 1'b1;
                        exc_addr_o    <= r_addr;
                        r_state       <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Directed bench for jedro_1_lsu: a vector table of single-shot accesses plus hand-written
// sequences for wait states, exceptions, timeout and reset mid-access.
module tb_jedro_1_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ctrl_valid_i = 1'b0;
    logic        ctrl_ready_o;
    logic        ctrl_we_i = 1'b0;
    logic [1:0]  ctrl_size_i = 2'b00;
    logic        ctrl_unsigned_i = 1'b0;
    logic [31:0] ctrl_addr_i = '0;
    logic [31:0] ctrl_wdata_i = '0;
    logic [4:0]  ctrl_regdest_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        done_o;
    logic        exc_misaligned_o;
    logic        exc_bus_err_o;
    logic        exc_timeout_o;
    logic [31:0] exc_addr_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    jedro_1_lsu #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ctrl_valid_i     (ctrl_valid_i),
        .ctrl_ready_o     (ctrl_ready_o),
        .ctrl_we_i        (ctrl_we_i),
        .ctrl_size_i      (ctrl_size_i),
        .ctrl_unsigned_i  (ctrl_unsigned_i),
        .ctrl_addr_i      (ctrl_addr_i),
        .ctrl_wdata_i     (ctrl_wdata_i),
        .ctrl_regdest_i   (ctrl_regdest_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .done_o           (done_o),
        .exc_misaligned_o (exc_misaligned_o),
        .exc_bus_err_o    (exc_bus_err_o),
        .exc_timeout_o    (exc_timeout_o),
        .exc_addr_o       (exc_addr_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_rvalid_i    (data_rvalid_i),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_rdata_i     (data_rdata_i),
        .data_err_i       (data_err_i)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd);
        ctrl_valid_i    = 1'b1;
        ctrl_we_i       = we;
        ctrl_size_i     = size;
        ctrl_unsigned_i = uns;
        ctrl_addr_i     = addr;
        ctrl_wdata_i    = wdata;
        ctrl_regdest_i  = rd;
    endtask

    // Zero-wait access: grant in the first REQ cycle, response in the first RESP cycle.
    task automatic run_vec(input vec_t v, input logic [4:0] rd);
        chk("ready_idle", 32'(ctrl_ready_o), 32'd1);
        drive_req(v.we, v.size, v.uns, v.addr, v.wdata, rd);
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        chk("req_high", 32'(data_req_o), 32'd1);
        chk("ready_busy", 32'(ctrl_ready_o), 32'd0);
        chk("bus_we", 32'(data_we_o), 32'(v.we));
        chk("bus_be", 32'(data_be_o), 32'(v.exp_be));
        chk("bus_addr", data_addr_o, v.exp_addr);
        if (v.we) chk("bus_wdata", data_wdata_o, v.exp_wdata);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        chk("req_low_resp", 32'(data_req_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = v.rdata;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("rf_we_pulse", 32'(rf_we_o), 32'(!v.we));
        if (!v.we) begin
            chk("rf_wdata", rf_wdata_o, v.exp_rf);
            chk("rf_waddr", 32'(rf_waddr_o), 32'(rd));
        end
        @(negedge clk_i);
        chk("done_single", 32'(done_o), 32'd0);
        chk("rf_we_single", 32'(rf_we_o), 32'd0);
    endtask

    initial begin
        //            we    size   uns   addr         wdata         rdata         be
        //            bus addr     bus wdata     rf data
        vecs[0] = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 4'b1000,
                    32'h100, 32'h0, 32'hFFFF_FF80};
        vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_FFFF, 4'b1000,
                    32'h100, 32'h0, 32'h0000_0080};
        vecs[2] = '{1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 32'h8001_7FFF, 4'b1100,
                    32'h010, 32'h0, 32'hFFFF_8001};
        vecs[3] = '{1'b0, 2'b01, 1'b1, 32'h010, 32'h0, 32'h1234_F00D, 4'b0011,
                    32'h010, 32'h0, 32'h0000_F00D};
        vecs[4] = '{1'b0, 2'b10, 1'b0, 32'h024, 32'h0, 32'hDEAD_BEEF, 4'b1111,
                    32'h024, 32'h0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 2'b00, 1'b0, 32'h041, 32'h0, 32'h0000_7F00, 4'b0010,
                    32'h040, 32'h0, 32'h0000_007F};
        vecs[6] = '{1'b1, 2'b00, 1'b0, 32'h052, 32'h1234_56A5, 32'h0, 4'b0100,
                    32'h050, 32'hA5A5_A5A5, 32'h0};
        vecs[7] = '{1'b1, 2'b10, 1'b0, 32'h060, 32'hCAFE_F00D, 32'h0, 4'b1111,
                    32'h060, 32'hCAFE_F00D, 32'h0};
        vecs[8] = '{1'b1, 2'b01, 1'b0, 32'h070, 32'hFFFF_1357, 32'h0, 4'b0011,
                    32'h070, 32'h1357_1357, 32'h0};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_exc_addr", exc_addr_o, 32'd0);
        chk("rst_ready", 32'(ctrl_ready_o), 32'd1);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], 5'(i + 1));

        // Store half with the grant held off for three cycles; a stray request is ignored.
        drive_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 5'd0);
        @(negedge clk_i);
        drive_req(1'b0, 2'b10, 1'b0, 32'h999, 32'h0, 5'd3);
        for (int c = 0; c < 4; c++) begin
            chk("wait_req", 32'(data_req_o), 32'd1);
            chk("wait_be", 32'(data_be_o), 32'b1100);
            chk("wait_addr", data_addr_o, 32'h200);
            chk("wait_wdata", data_wdata_o, 32'hABCD_ABCD);
            chk("wait_we", 32'(data_we_o), 32'd1);
            if (c == 3) begin
                ctrl_valid_i = 1'b0;
                data_gnt_i   = 1'b1;
            end
            @(negedge clk_i);
        end
        data_gnt_i = 1'b0;
        chk("wait_req_drop", 32'(data_req_o), 32'd0);
        data_rvalid_i = 1'b1;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        chk("wait_done", 32'(done_o), 32'd1);
        chk("wait_no_rf_we", 32'(rf_we_o), 32'd0);
        @(negedge clk_i);
        chk("wait_idle_req", 32'(data_req_o), 32'd0);

        // Misaligned word.
        drive_req(1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 5'd4);
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        chk("mis_pulse", 32'(exc_misaligned_o), 32'd1);
        chk("mis_addr", exc_addr_o, 32'h301);
        chk("mis_no_req", 32'(data_req_o), 32'd0);
        chk("mis_ready", 32'(ctrl_ready_o), 32'd1);
        @(negedge clk_i);
        chk("mis_single", 32'(exc_misaligned_o), 32'd0);
        chk("mis_no_req2", 32'(data_req_o), 32'd0);

        // Bus error on a load.
        drive_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd6);
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        data_gnt_i   = 1'b1;
        @(negedge clk_i);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_err_i    = 1'b1;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        chk("berr_pulse", 32'(exc_bus_err_o), 32'd1);
        chk("berr_addr", exc_addr_o, 32'h400);
        chk("berr_no_rf_we", 32'(rf_we_o), 32'd0);
        chk("berr_no_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        chk("berr_single", 32'(exc_bus_err_o), 32'd0);

        // Timeout with the grant never arriving, then a late response in IDLE.
        drive_req(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd7);
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("to_req_held", 32'(data_req_o), 32'd1);
            chk("to_no_pulse", 32'(exc_timeout_o), 32'd0);
            @(negedge clk_i);
        end
        chk("to_pulse", 32'(exc_timeout_o), 32'd1);
        chk("to_req_drop", 32'(data_req_o), 32'd0);
        chk("to_addr", exc_addr_o, 32'h500);
        chk("to_ready", 32'(ctrl_ready_o), 32'd1);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_1111;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        chk("to_single", 32'(exc_timeout_o), 32'd0);
        @(negedge clk_i);
        chk("late_no_done", 32'(done_o), 32'd0);
        chk("late_no_rf_we", 32'(rf_we_o), 32'd0);

        // Reset taken in RESP, then a stale response.
        drive_req(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd9);
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        data_gnt_i   = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("mrst_req", 32'(data_req_o), 32'd0);
        chk("mrst_addr", data_addr_o, 32'd0);
        chk("mrst_be", 32'(data_be_o), 32'd0);
        chk("mrst_exc_addr", exc_addr_o, 32'd0);
        chk("mrst_done", 32'(done_o), 32'd0);
        chk("mrst_ready", 32'(ctrl_ready_o), 32'd1);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h2222_2222;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("mrst_stale_done", 32'(done_o), 32'd0);
        chk("mrst_stale_rf_we", 32'(rf_we_o), 32'd0);
        chk("mrst_stale_rf_wdata", rf_wdata_o, 32'd0);
        chk("mrst_stale_berr", 32'(exc_bus_err_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jedro_1_lsu.md
JEDRO_1_LSU -- requirements
Module: jedro_1_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data bus width; legal values are 32 and 64.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, SHALL set the register destination address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, SHALL set the bus timeout limit; 0 disables the timeout.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
REQ-005 The control side SHALL consist of:
- ctrl_valid_i  in  1  new access request.
- ctrl_ready_o  out  1  LSU idle, request accepted this cycle.
- ctrl_we_i  in  1  1 = store, 0 = load.
- ctrl_size_i  in  2  00 byte, 01 half, 10 word, 11 double.
- ctrl_unsigned_i  in  1  zero-extend loads.
- ctrl_addr_i  in  DATA_WIDTH  byte address.
- ctrl_wdata_i  in  DATA_WIDTH  store data, LSB-aligned.
- ctrl_regdest_i  in  REG_ADDR_WIDTH  load destination.
REQ-006 The writeback and status side SHALL consist of:
- rf_we_o  out  1  one-cycle register write strobe.
- rf_waddr_o  out  REG_ADDR_WIDTH  write address.
- rf_wdata_o  out  DATA_WIDTH  extended load data.
- done_o  out  1  one-cycle access-complete pulse.
- exc_misaligned_o, exc_bus_err_o, exc_timeout_o  out  1 each  one-cycle exception pulses.
- exc_addr_o  out  DATA_WIDTH  faulting address, held until the next exception.
REQ-007 The bus side SHALL consist of:
- data_req_o  out  1
- data_gnt_i  in  1
- data_rvalid_i  in  1
- data_we_o  out  1
- data_be_o  out  DATA_WIDTH/8
- data_addr_o  out  DATA_WIDTH
- data_wdata_o  out  DATA_WIDTH
- data_rdata_i  in  DATA_WIDTH
- data_err_i  in  1

Function
REQ-008 The FSM SHALL have the states IDLE, REQ and RESP; ctrl_ready_o SHALL be 1 only in IDLE.
REQ-009 In IDLE, on ctrl_valid_i, an access is illegal when:
- its size is misaligned (half: addr[0] is not 0; word: addr[1:0] is not 0; double: addr[2:0] is not 0), or
- size is 11 with DATA_WIDTH=32.
An illegal access SHALL pulse exc_misaligned_o in the next cycle, load exc_addr_o, issue no bus request and stay in IDLE.
REQ-010 A legal accepted access SHALL register all ctrl inputs and go to REQ; data_req_o SHALL be 1 in the next cycle.
REQ-011 In REQ, data_req_o, data_we_o, data_be_o, data_addr_o and data_wdata_o SHALL stay stable until the cycle in which data_gnt_i=1.
- The cycle with data_gnt_i=1 completes the handshake, and the FSM SHALL go to RESP.
- data_req_o SHALL be 0 in RESP.
REQ-012 data_addr_o SHALL be the accepted address with its offset bits cleared (word/double aligned).
REQ-013 data_be_o SHALL be:
- byte: 1 shifted left by the offset;
- half: 0b11 shifted left by the offset;
- word: 0xF shifted left by the offset;
- double: all ones.
REQ-014 data_wdata_o SHALL hold the store data replicated across the bus: byte in every byte lane, half in every half lane.
REQ-015 In RESP, data_rvalid_i is honoured no earlier than the cycle after the grant.
- On data_rvalid_i with data_err_i=1: in the next cycle, pulse exc_bus_err_o and load exc_addr_o; no rf_we_o, no done_o.
- On data_rvalid_i with data_err_i=0: in the next cycle, pulse done_o; for loads also pulse rf_we_o with rf_waddr_o = the registered regdest.
- In both cases the FSM SHALL return to IDLE.
REQ-016 The rf_wdata_o load data SHALL be formed by shifting data_rdata_i right by offset*8, then sign-extending from the access size, or zero-extending when ctrl_unsigned_i was set.
REQ-017 While TIMEOUT_CYCLES > 0, a cycle counter SHALL count every cycle spent in REQ plus RESP.
- When the count reaches TIMEOUT_CYCLES: pulse exc_timeout_o and load exc_addr_o in the next cycle, drop data_req_o and return to IDLE.
- A late data_rvalid_i arriving in IDLE SHALL be ignored.
REQ-018 A ctrl_valid_i presented outside IDLE SHALL be ignored and not queued.
REQ-019 At most one bus transaction SHALL be outstanding at a time.

Reset
REQ-020 While rst_i=1 at a clock edge, the following SHALL be 0 after that edge, and the FSM SHALL be in IDLE with the timeout counter cleared:
- data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o;
- rf_we_o, rf_waddr_o, rf_wdata_o;
- done_o and all exc_* outputs, including exc_addr_o.
ctrl_ready_o SHALL be 1 after that edge.
REQ-021 A reset taken in REQ or RESP SHALL abort the access with no done, writeback or exception pulse.

Verification
REQ-022 A bench SHALL cover these directed scenarios:
- Signed byte load: addr 0x103, rdata 0x80FFFFFF, gnt in the first REQ cycle, rvalid the next cycle -> be=0b1000, addr=0x100, rf_wdata_o=0xFFFFFF80, rf_we_o and done_o a single pulse each.
- Store half: addr 0x202, wdata 0x0000ABCD, gnt delayed 3 cycles -> data_req_o and outputs stable for 4 cycles, be=0b1100, wdata=0xABCDABCD, done_o pulse, no rf_we_o.
- Misaligned word: addr 0x301 -> exc_misaligned_o pulse, exc_addr_o=0x301, data_req_o stays 0.
- Bus error on load: rvalid with err=1 -> exc_bus_err_o pulse, no rf_we_o.
- Timeout: TIMEOUT_CYCLES=16 with gnt never asserted -> exc_timeout_o 16 cycles after REQ entry, data_req_o drops.
- Reset mid-access: rst_i in RESP -> all outputs 0 next cycle, no pulses; a subsequent rvalid is ignored.
